// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/ack instruction-memory handshake, holds it for decode/execute until
// the controller retires it, then steps the PC according to npc_op.
// A misaligned register-indirect jump target parks the unit in a sticky
// FAULT state that only reset clears.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  // instruction memory handshake
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // decode / execute interface
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [2:0]  npc_op,
  input  logic        zero,
  input  logic [31:0] ra_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [2:0] NPC_SEQ    = 3'b000;
  localparam logic [2:0] NPC_BEQ    = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic        req_next;
  logic        valid_next;
  logic        fault_next;

  logic [31:0] npc;
  logic [31:0] branch_offset;
  logic        jr_misaligned;

  // The fetch address is the PC itself; it only changes on retire, so it is
  // stable for the whole time imem_req is high.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Sign-extended word offset of the beq immediate, relative to pc+4.
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Only register-indirect targets can be misaligned; every other target is
  // built from word-aligned pieces.
  assign jr_misaligned = (npc_op == NPC_JR) && (ra_data[1:0] != 2'b00);

  // Next-PC selection; only consumed in HOLD when the instruction retires.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    npc = pc_plus4;
    if (npc_op[2] == 1'b0) begin
      unique case (npc_op[1:0])
        NPC_SEQ[1:0]:  npc = pc_plus4;
        NPC_BEQ[1:0]:  npc = zero ? (pc_plus4 + branch_offset) : pc_plus4;
        NPC_JUMP[1:0]: npc = {pc_plus4[31:28], instr[25:0], 2'b00};
        NPC_JR[1:0]:   npc = ra_data;
        default:       npc = pc_plus4;
      endcase
    end
  end

  // Next-state and next-output logic of the fetch FSM.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    req_next   = imem_req;
    valid_next = instr_valid;
    fault_next = fault;

    unique case (state)
      IDLE: begin
        // Leaving reset: start the first fetch at RESET_PC.
        state_next = FETCH;
        req_next   = 1'b1;
      end

      FETCH: begin
        // Request and address are held until memory accepts.
        if (imem_ack) begin
          instr_next = imem_rdata;
          req_next   = 1'b0;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (instr_ready) begin
          pc_next    = npc;
          valid_next = 1'b0;
          if (jr_misaligned) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end else begin
            req_next   = 1'b1;
            state_next = FETCH;
          end
        end
      end

      FAULT: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
        fault_next = 1'b1;
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset is asynchronous so a reset mid-fetch
  // drops imem_req and instr_valid immediately.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      imem_req    <= req_next;
      instr_valid <= valid_next;
      fault       <= fault_next;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: acts as instruction memory (random ack
// latency) and as controller (random retire latency, random npc_op/zero/
// ra_data), and checks every fetch address and PC step against a reference
// next-PC computed directly from the MIPS jump/branch rules.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic        zero = 1'b0;
  logic [31:0] ra_data = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_pc;
  bit          exp_fault;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .npc_op      (npc_op),
    .zero        (zero),
    .ra_data     (ra_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural next PC, straight from the instruction-set rules.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [2:0] op,
                                          input logic z, input logic [31:0] ra,
                                          input logic [31:0] w);
    int imm;
    imm = $signed(w[15:0]);
    case (op)
      3'd1:    return z ? (cur + 32'd4 + 32'(imm * 4)) : (cur + 32'd4);
      3'd2:    return ((cur + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      3'd3:    return ra;
      default: return cur + 32'd4;
    endcase
  endfunction

  task automatic scramble_ctrl();
    npc_op  = 3'($urandom);
    zero    = 1'($urandom);
    ra_data = $urandom;
  endtask

  // Reset pulse; with mid=1 rstn falls between clock edges so the async
  // drop of req/valid is observed before any edge.
  task automatic reset_dut(input bit mid);
    @(negedge clk);
    if (mid) #2;
    rstn = 1'b0;
    imem_ack = 1'b1;              // ack arriving during reset must be ignored
    imem_rdata = $urandom;
    instr_ready = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    check("first_pc4", pc_plus4, RESET_PC + 32'd4);
    exp_pc = RESET_PC;
    exp_fault = 1'b0;
  endtask

  // One full fetch/hold/retire transaction. Entered at a negedge with the
  // request expected to be already up.
  task automatic do_instr(input int ack_dly, input int rdy_dly, input logic [2:0] op,
                          input logic z, input logic [31:0] ra, input logic [31:0] word);
    logic [31:0] exp_npc;
    bit          misal;
    check("req_up", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      instr_ready = 1'($urandom);
      scramble_ctrl();
      @(negedge clk);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    instr_ready = 1'($urandom);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, word);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_pc", pc, exp_pc);
    check("hold_pc4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready = 1'b0;
      scramble_ctrl();
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, word);
      check("stall_pc", pc, exp_pc);
    end
    instr_ready = 1'b1;
    npc_op = op;
    zero = z;
    ra_data = ra;
    exp_npc = ref_npc(exp_pc, op, z, ra, word);
    misal = (op == 3'd3) && (ra[1:0] != 2'b00);
    @(negedge clk);
    instr_ready = 1'b0;
    scramble_ctrl();
    check("retire_valid", {31'd0, instr_valid}, 32'd0);
    check("retire_pc", pc, exp_npc);
    check("retire_fault", {31'd0, fault}, {31'd0, misal});
    check("retire_req", {31'd0, imem_req}, {31'd0, !misal});
    if (!misal) check("next_addr", imem_addr, exp_npc);
    exp_pc = exp_npc;
    exp_fault = misal;
  endtask

  task automatic check_fault_parked();
    for (int i = 0; i < 3; i++) begin
      instr_ready = 1'b1;
      imem_ack = 1'($urandom);
      @(negedge clk);
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_noreq", {31'd0, imem_req}, 32'd0);
      check("fault_novalid", {31'd0, instr_valid}, 32'd0);
    end
    instr_ready = 1'b0;
    imem_ack = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] ra;
    exp_pc = RESET_PC;
    exp_fault = 1'b0;

    // Back-to-back sequential fetches, ack always immediate.
    reset_dut(1'b0);
    do_instr(0, 0, 3'd0, 1'b0, 32'd0, 32'h2001_0001);
    do_instr(0, 0, 3'd0, 1'b0, 32'd0, 32'h2002_0002);
    // beq with imm=-1 at 0x3008: taken loops to itself, not taken falls through.
    do_instr(0, 1, 3'd1, 1'b1, 32'd0, 32'h1022_FFFF);
    check("beq_taken", exp_pc, 32'h0000_3008);
    do_instr(1, 0, 3'd1, 1'b0, 32'd0, 32'h1022_FFFF);
    check("beq_fall", exp_pc, 32'h0000_300C);
    // Slow memory: ack after 3 waiting cycles.
    do_instr(3, 0, 3'd0, 1'b0, 32'd0, 32'h3C01_1234);
    // jal at 0x3010.
    do_instr(0, 0, 3'd2, 1'b0, 32'd0, 32'h0C00_0C40);
    check("jal_target", exp_pc, 32'h0000_3100);
    // Reserved npc_op value behaves as pc+4.
    do_instr(0, 2, 3'd6, 1'b1, 32'h1234_5678, 32'h1000_0010);
    // PC wrap at the top of the address space.
    do_instr(0, 0, 3'd3, 1'b0, 32'hFFFF_FFFC, 32'h0020_0008);
    do_instr(2, 0, 3'd0, 1'b0, 32'd0, 32'h0000_0000);
    check("wrap_pc", exp_pc, 32'h0000_0000);

    // Reset while a request is outstanding.
    reset_dut(1'b1);

    // Misaligned jr target -> sticky fault, cleared only by reset.
    do_instr(0, 0, 3'd3, 1'b0, 32'h0000_3002, 32'h0020_0008);
    check_fault_parked();
    reset_dut(1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom & 32'hFFFF_FFFC;
      if (op == 3'd3 && $urandom_range(0, 9) == 0) ra = ra | 32'($urandom_range(1, 3));
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), op, 1'($urandom), ra, $urandom);
      if (exp_fault) begin
        check_fault_parked();
        reset_dut(1'($urandom));
      end else if ($urandom_range(0, 29) == 0) begin
        reset_dut(1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
